fetch_sequencer: RTL and testbench

- Program-counter and image-select controller in front of the single-cycle CPU's two-image instruction memory.
- Owns the PC register and the ROM image select (0 = image 0, 1 = image 1).
- Sequences program switching with flush bubbles and halts fetch when the PC runs past the active image.
- Counts retired fetches per program run.

---
 rtl/fetch_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Owns the program counter and the image select for the single-cycle CPU's
// two-image instruction memory. It steps the PC from the datapath's next-PC
// value. It halts fetch when the PC runs past the end of the active image. It
// also sequences program switches: the PC is reset, a fixed number of flush
// bubbles is inserted, and the switch is acknowledged. The block counts
// retired fetches per program run, and the count saturates at 16'hFFFF.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   run          fetch enable from board control
//   stall        datapath hold; PC and retire count frozen while high
//   pc_next_in   next PC from datapath (bits [1:0] ignored)
//   switch_req   request to restart on another image (level or pulse)
//   switch_to    target image, sampled together with switch_req
//   pc           current fetch address
//   rom_sel      image select (0 = image 0, 1 = image 1)
//   fetch_valid  instruction at pc is executed/retired this cycle
//   halted       fetch stopped because the PC left the active image
//   switch_ack   one-cycle pulse when a switch has been applied
//   instr_count  retired fetches since last reset/switch, saturating
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int unsigned DEPTH0       = 336,
  parameter int unsigned DEPTH1       = 77,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        stall,
  input  logic [31:0] pc_next_in,
  input  logic        switch_req,
  input  logic        switch_to,
  output logic [31:0] pc,
  output logic        rom_sel,
  output logic        fetch_valid,
  output logic        halted,
  output logic        switch_ack,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [29:0] DEPTH0_W   = 30'(DEPTH0);
  localparam logic [29:0] DEPTH1_W   = 30'(DEPTH1);
  // The flush counter exits on zero, so loading N-1 yields N bubble cycles.
  localparam logic [3:0]  FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      r_state,      w_state_nxt;
  logic [31:0] r_pc,         w_pc_nxt;
  logic        r_rom_sel,    w_rom_sel_nxt;
  logic [15:0] r_count,      w_count_nxt;
  logic [3:0]  r_flush_cnt,  w_flush_cnt_nxt;
  logic        r_pending,    w_pending_nxt;
  logic        r_target,     w_target_nxt;
  logic        r_switch_ack, w_switch_ack_nxt;

  logic        w_pend;
  logic        w_tgt;
  logic        w_can_apply;
  logic        w_apply;
  logic        w_in_range;
  logic [31:0] w_pc_fetch;
  logic [15:0] w_count_inc;
  logic        w_unused_lsbs;

  // A request present at this edge counts as pending already. As a result, a
  // switch presented while idle reaches its first fetch after FLUSH_CYCLES+1
  // cycles.
  assign w_pend = r_pending | switch_req;
  assign w_tgt  = switch_req ? switch_to : r_target;

  assign w_pc_fetch    = {pc_next_in[31:2], 2'b00};
  assign w_unused_lsbs = ^pc_next_in[1:0];

  // The range check is applied to the PC being loaded. Any high address bit
  // set means the PC is out of range, whatever the image depth.
  assign w_in_range = (pc_next_in[31:11] == '0) &&
                      (pc_next_in[31:2] < (r_rom_sel ? DEPTH1_W : DEPTH0_W));

  assign w_count_inc = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;

  // A switch may only break in at a cycle boundary where nothing is in
  // flight: idle, halted, an unstalled fetch, or the last flush bubble.
  always_comb begin
    w_can_apply = 1'b0;
    unique case (r_state)
      S_IDLE:  w_can_apply = 1'b1;
      S_HALT:  w_can_apply = 1'b1;
      S_FETCH: w_can_apply = !stall;
      S_FLUSH: w_can_apply = (r_flush_cnt == 4'd0);
      default: w_can_apply = 1'b0;
    endcase
  end

  assign w_apply = w_pend && w_can_apply;

  // NOTE: every signal written here receives a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_rom_sel_nxt    = r_rom_sel;
    w_count_nxt      = r_count;
    w_flush_cnt_nxt  = r_flush_cnt;
    w_pending_nxt    = w_pend;
    w_target_nxt     = w_tgt;
    w_switch_ack_nxt = 1'b0;

    if (w_apply) begin
      // A switch overrides anything else this cycle, including a halt on an
      // out-of-range next PC. The switching fetch does not retire.
      w_state_nxt      = S_FLUSH;
      w_pc_nxt         = RESET_PC;
      w_rom_sel_nxt    = w_tgt;
      w_count_nxt      = 16'd0;
      w_flush_cnt_nxt  = FLUSH_INIT;
      w_pending_nxt    = 1'b0;
      w_switch_ack_nxt = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (run) w_state_nxt = S_FETCH;
        end
        S_FETCH: begin
          if (!stall) begin
            w_count_nxt = w_count_inc;
            if (!run) begin
              // The fetch in this cycle retires, but the PC stays put.
              w_state_nxt = S_IDLE;
            end else begin
              w_pc_nxt = w_pc_fetch;
              if (!w_in_range) w_state_nxt = S_HALT;
            end
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == 4'd0) begin
            w_state_nxt = run ? S_FETCH : S_IDLE;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - 4'd1;
          end
        end
        S_HALT: begin
          // Held until a switch or reset; run is ignored.
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge values and simulation order cannot create races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_rom_sel    <= 1'b0;
      r_count      <= 16'd0;
      r_flush_cnt  <= 4'd0;
      r_pending    <= 1'b0;
      r_target     <= 1'b0;
      r_switch_ack <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_rom_sel    <= w_rom_sel_nxt;
      r_count      <= w_count_nxt;
      r_flush_cnt  <= w_flush_cnt_nxt;
      r_pending    <= w_pending_nxt;
      r_target     <= w_target_nxt;
      r_switch_ack <= w_switch_ack_nxt;
    end
  end

  assign pc          = r_pc;
  assign rom_sel     = r_rom_sel;
  assign instr_count = r_count;
  assign switch_ack  = r_switch_ack;
  assign halted      = (r_state == S_HALT);
  assign fetch_valid = (r_state == S_FETCH) && !stall;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. A behavioural model tracks the
// program position as a few plain flags and counters (bubbles left, halted,
// active, pending switch) and predicts every output each cycle. Directed
// scenarios are followed by a randomized phase and a saturation run.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int unsigned DEPTH0   = 336;
  localparam int unsigned DEPTH1   = 77;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned FLUSH    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        stall;
  logic [31:0] pc_next_in;
  logic        switch_req;
  logic        switch_to;
  logic [31:0] pc;
  logic        rom_sel;
  logic        fetch_valid;
  logic        halted;
  logic        switch_ack;
  logic [15:0] instr_count;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .DEPTH0      (DEPTH0),
    .DEPTH1      (DEPTH1),
    .RESET_PC    (RESET_PC),
    .FLUSH_CYCLES(FLUSH)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .stall      (stall),
    .pc_next_in (pc_next_in),
    .switch_req (switch_req),
    .switch_to  (switch_to),
    .pc         (pc),
    .rom_sel    (rom_sel),
    .fetch_valid(fetch_valid),
    .halted     (halted),
    .switch_ack (switch_ack),
    .instr_count(instr_count)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_pc     = RESET_PC;
  bit          m_sel    = 1'b0;
  int          m_cnt    = 0;
  int          m_flush  = 0;     // bubble cycles still to come
  bit          m_active = 1'b0;  // fetching (as opposed to idle)
  bit          m_halt   = 1'b0;
  bit          m_ack    = 1'b0;
  bit          m_pend   = 1'b0;
  bit          m_tgt    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_fetch_valid(input bit s);
    return m_active && !m_halt && (m_flush == 0) && !s;
  endfunction

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input bit r, input bit s, input logic [31:0] nx,
                            input bit rq, input bit to);
    bit pend;
    bit tgt;
    bit can;
    longint depth;
    m_ack = 1'b0;
    if (!rst_n) begin
      m_pc = RESET_PC; m_sel = 1'b0; m_cnt = 0; m_flush = 0;
      m_active = 1'b0; m_halt = 1'b0; m_pend = 1'b0; m_tgt = 1'b0;
      return;
    end
    pend = m_pend || rq;
    tgt  = rq ? to : m_tgt;
    if (m_halt)           can = 1'b1;
    else if (m_flush > 0) can = (m_flush == 1);
    else if (m_active)    can = !s;
    else                  can = 1'b1;
    if (pend && can) begin
      m_pc = RESET_PC; m_sel = tgt; m_cnt = 0; m_flush = FLUSH;
      m_halt = 1'b0; m_active = 1'b0; m_ack = 1'b1; m_pend = 1'b0; m_tgt = tgt;
      return;
    end
    m_pend = pend;
    m_tgt  = tgt;
    if (m_halt) begin
      // nothing moves while halted
    end else if (m_flush > 0) begin
      m_flush--;
      if (m_flush == 0) m_active = r;
    end else if (!m_active) begin
      m_active = r;
    end else if (!s) begin
      if (m_cnt < 65535) m_cnt++;
      if (!r) begin
        m_active = 1'b0;
      end else begin
        m_pc  = nx & ~32'h3;
        depth = m_sel ? DEPTH1 : DEPTH0;
        if (longint'(m_pc >> 2) >= depth) begin
          m_halt   = 1'b1;
          m_active = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("pc",          pc,          m_pc);
    check("rom_sel",     rom_sel,     32'(m_sel));
    check("halted",      halted,      32'(m_halt));
    check("switch_ack",  switch_ack,  32'(m_ack));
    check("instr_count", instr_count, 32'(m_cnt));
  endtask

  // Called at a falling edge: drive, check the combinational valid, clock,
  // then compare registered outputs at the next falling edge.
  task automatic step(input logic r, input logic s, input logic [31:0] nx,
                      input logic rq, input logic to);
    run = r; stall = s; pc_next_in = nx; switch_req = rq; switch_to = to;
    #1;
    check("fetch_valid", fetch_valid, 32'(exp_fetch_valid(s)));
    @(posedge clk);
    model_step(r, s, nx, rq, to);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int ack_seen;
    rst_n = 1'b0; run = 1'b0; stall = 1'b0; pc_next_in = '0;
    switch_req = 1'b0; switch_to = 1'b0;
    @(posedge clk);
    model_step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check_outputs();
    check("reset_fetch_valid", fetch_valid, 32'd0);
    rst_n = 1'b1;

    // 1: sequential fetch from image 0
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, pc + 32'd4, 1'b0, 1'b0);
    check("t1_count", instr_count, 32'd10);
    check("t1_pc", pc, 32'd40);
    check("t1_rom_sel", rom_sel, 32'd0);

    // 2: switch to image 1 and run off its end
    step(1'b1, 1'b0, pc + 32'd4, 1'b1, 1'b1);
    for (int i = 0; i < 200 && !halted; i++) step(1'b1, 1'b0, pc + 32'd4, 1'b0, 1'b0);
    check("t2_halted", halted, 32'd1);
    check("t2_pc", pc, 32'h134);
    check("t2_count", instr_count, 32'd77);
    check("t2_fetch_valid", fetch_valid, 32'd0);

    // 3: switch requested under stall is deferred until stall drops
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, pc + 32'd4, 1'b0, 1'b0);
    step(1'b1, 1'b1, pc + 32'd4, 1'b1, 1'b1);
    step(1'b1, 1'b1, pc + 32'd4, 1'b0, 1'b0);
    step(1'b1, 1'b1, pc + 32'd4, 1'b0, 1'b0);
    check("t3_no_ack_stalled", switch_ack, 32'd0);
    step(1'b1, 1'b0, pc + 32'd4, 1'b0, 1'b0);
    check("t3_ack", switch_ack, 32'd1);
    check("t3_pc", pc, 32'd0);
    check("t3_rom_sel", rom_sel, 32'd1);
    step(1'b1, 1'b0, pc + 32'd4, 1'b0, 1'b0);
    step(1'b1, 1'b0, pc + 32'd4, 1'b0, 1'b0);
    stall = 1'b0;
    #1;
    check("t3_fetch_valid", fetch_valid, 32'd1);

    // 4: switch beats an out-of-range next PC
    step(1'b1, 1'b0, pc + 32'd4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, pc + 32'd4, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h540, 1'b1, 1'b0);
    check("t4_no_halt", halted, 32'd0);
    check("t4_pc", pc, 32'd0);
    check("t4_ack", switch_ack, 32'd1);

    // 5: second request during flush re-enters flush after FLUSH cycles
    ack_seen = 0;
    for (int i = 0; i < FLUSH; i++) begin
      step(1'b1, 1'b0, pc + 32'd4, (i == 0), 1'b1);
      if (switch_ack) ack_seen++;
    end
    check("t5_second_ack", switch_ack, 32'd1);
    check("t5_ack_count", 32'(ack_seen), 32'd1);
    for (int i = 0; i < FLUSH; i++) step(1'b1, 1'b0, pc + 32'd4, 1'b0, 1'b0);
    check("t5_rom_sel", rom_sel, 32'd1);

    // 6: wild next PC halts; reset mid-flush aborts the switch
    step(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("t6_halted", halted, 32'd1);
    check("t6_pc", pc, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1);
    rst_n = 1'b1;
    check("t6_rst_pc", pc, 32'd0);
    check("t6_rst_rom_sel", rom_sel, 32'd0);
    check("t6_rst_count", instr_count, 32'd0);
    check("t6_rst_halted", halted, 32'd0);
    check("t6_rst_ack", switch_ack, 32'd0);
    run = 1'b0;
    #1;
    check("t6_rst_fetch_valid", fetch_valid, 32'd0);

    // 7: randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int unsigned sel;
      logic [31:0] nx;
      sel = $urandom_range(0, 9);
      if (sel < 8)       nx = pc + 32'd4;
      else if (sel == 8) nx = $urandom_range(0, 32'h7FF);
      else               nx = $urandom;
      rst_n = ($urandom_range(0, 199) != 0);
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0), nx,
           ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    end
    rst_n = 1'b1;

    // 8: retire count saturates
    do_reset();
    for (int i = 0; i < 70001; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t8_saturated", instr_count, 32'hFFFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
